// File: rtl/instr_mix_profiler.sv
// Instruction-mix profiler: classifies issued RV32 words into 12 classes, counts per class plus total.
// Latency: counters update at the edge after the event; rd_data is registered (one cycle after rd_sel).
// Backpressure: none; sustains one counted instruction per cycle with no stall.
module instr_mix_profiler #(
    parameter int unsigned     CNT_W      = 32,
    parameter bit              SATURATE   = 1'b1,
    parameter bit              DEDUP      = 1'b1,
    parameter longint unsigned WINDOW_LEN = 64'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             snap_req,
    input  logic             rd_bank,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             snap_done,
    output logic             any_ovf
);

    localparam int unsigned NCNT = 13;   // 12 class counters + total
    localparam int unsigned TOT  = 12;   // index of the total counter
    localparam bit          WIN_EN   = (WINDOW_LEN != 64'd0);
    // Only meaningful when WIN_EN; with WINDOW_LEN == 0 the roll condition is gated off.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 64'd1);

    // Class of an OP/OP-IMM instruction whose funct3 is not 000.
    function automatic logic [3:0] alu_f3_class(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b001, 3'b101:         c = 4'd5;   // shift
            3'b010, 3'b011:         c = 4'd6;   // compare
            3'b100, 3'b110, 3'b111: c = 4'd4;   // logic
            default:                c = 4'd2;   // funct3 000 on OP-IMM is an add
        endcase
        return c;
    endfunction

    // Map an instruction word to its class index 0..11.
    function automatic logic [3:0] classify(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] c;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        c   = 4'd11;
        case (opc)
            7'b0000011: c = 4'd0;               // load
            7'b0100011: c = 4'd1;               // store
            7'b0010111: c = 4'd2;               // AUIPC counts as add
            7'b0010011: c = alu_f3_class(f3);   // OP-IMM
            7'b0110011: begin                   // OP
                if (f7 == 7'b0000001) begin
                    c = 4'd11;                  // M-extension
                end else if (f3 == 3'b000) begin
                    if (f7 == 7'b0000000)      c = 4'd2;
                    else if (f7 == 7'b0100000) c = 4'd3;
                    else                       c = 4'd11;
                end else begin
                    c = alu_f3_class(f3);
                end
            end
            7'b1100011: c = 4'd7;               // branch
            7'b1101111,
            7'b1100111: c = 4'd8;               // JAL / JALR
            7'b1110011: c = 4'd9;               // system
            7'b0101111: c = 4'd10;              // atomic
            default:    c = 4'd11;
        endcase
        return c;
    endfunction

    // Live bank
    logic [CNT_W-1:0] cnt_q   [NCNT];
    logic [CNT_W-1:0] cnt_d   [NCNT];
    logic [CNT_W-1:0] upd_cnt [NCNT];
    logic [NCNT-1:0]  ovf_q, ovf_d, upd_ovf;

    // Shadow bank
    logic [CNT_W-1:0] sh_cnt_q [NCNT];
    logic [CNT_W-1:0] sh_cnt_d [NCNT];
    logic [NCNT-1:0]  sh_ovf_q, sh_ovf_d;

    // Dedup history and window position
    logic [31:0]      hist_q, hist_d;
    logic             hist_vld_q, hist_vld_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;

    // Outputs
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             snap_done_q, snap_done_d;
    logic             any_ovf_q, any_ovf_d;

    // Event qualification
    logic       dup;
    logic       cnt_evt;
    logic       win_roll;
    logic       sh_we;
    logic [3:0] cls;

    // Qualify the incoming word and decide window rollover.
    always_comb begin
        cls      = classify(instr);
        dup      = DEDUP && hist_vld_q && (instr == hist_q);
        cnt_evt  = enable && !clear && instr_valid && !dup;
        win_roll = WIN_EN && cnt_evt && (win_cnt_q == WIN_LAST);
        sh_we    = win_roll || snap_req;
    end

    // Incremented counter values and overflow flags, then live next-state.
    always_comb begin
        upd_ovf = ovf_q;
        for (int i = 0; i < NCNT; i++) begin
            upd_cnt[i] = cnt_q[i];
            if (cnt_evt && ((i == TOT) || (cls == 4'(i)))) begin
                if (&cnt_q[i]) begin
                    upd_ovf[i] = 1'b1;
                    upd_cnt[i] = SATURATE ? cnt_q[i] : '0;
                end else begin
                    upd_cnt[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Clear and window rollover both empty the live bank on this edge.
        ovf_d = (clear || win_roll) ? '0 : upd_ovf;
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = (clear || win_roll) ? '0 : upd_cnt[i];
        end
        any_ovf_d = |ovf_d;
    end

    // Shadow next-state: window snapshot includes this event, manual one does not.
    always_comb begin
        sh_ovf_d = sh_ovf_q;
        for (int i = 0; i < NCNT; i++) begin
            sh_cnt_d[i] = sh_cnt_q[i];
        end
        if (win_roll) begin
            sh_ovf_d = upd_ovf;
            for (int i = 0; i < NCNT; i++) begin
                sh_cnt_d[i] = upd_cnt[i];
            end
        end else if (snap_req) begin
            sh_ovf_d = ovf_q;
            for (int i = 0; i < NCNT; i++) begin
                sh_cnt_d[i] = cnt_q[i];
            end
        end
        snap_done_d = sh_we;
    end

    // History and window counter next-state; hist survives a window rollover.
    always_comb begin
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        win_cnt_d  = win_cnt_q;
        if (cnt_evt) begin
            hist_d     = instr;
            hist_vld_d = 1'b1;
        end
        if (clear) begin
            hist_d     = '0;
            hist_vld_d = 1'b0;
        end
        if (!WIN_EN || clear || win_roll) begin
            win_cnt_d = '0;
        end else if (cnt_evt) begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
        end
    end

    // Read mux: selects from registered state, result registered below.
    always_comb begin
        rd_data_d = '0;
        if (rd_sel < 4'd13) begin
            rd_data_d = rd_bank ? sh_cnt_q[rd_sel] : cnt_q[rd_sel];
        end else if (rd_sel == 4'd13) begin
            rd_data_d = CNT_W'(rd_bank ? sh_ovf_q : ovf_q);
        end
    end

    // Live bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q     <= '0;
            any_ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q     <= ovf_d;
            any_ovf_q <= any_ovf_d;
        end
    end

    // Shadow bank registers and capture pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                sh_cnt_q[i] <= '0;
            end
            sh_ovf_q    <= '0;
            snap_done_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                sh_cnt_q[i] <= sh_cnt_d[i];
            end
            sh_ovf_q    <= sh_ovf_d;
            snap_done_q <= snap_done_d;
        end
    end

    // Dedup history, window position and read data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            win_cnt_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            win_cnt_q  <= win_cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign snap_done = snap_done_q;
    assign any_ovf   = any_ovf_q;

endmodule

// File: tb/tb_instr_mix_profiler.sv
// Self-checking bench for instr_mix_profiler: classification table plus multi-cycle corner sequences.
// Five instances share stimulus: default, DEDUP=0, 13-bit saturating, 13-bit wrapping, WINDOW_LEN=4.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.
module tb_instr_mix_profiler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [31:0] instr;
    logic        instr_valid;
    logic        snap_req;
    logic        rd_bank;
    logic [3:0]  rd_sel;

    logic [31:0] rd_m, rd_n, rd_win;
    logic [12:0] rd_s, rd_w;
    logic        sd_m, sd_n, sd_s, sd_w, sd_win;
    logic        ao_m, ao_n, ao_s, ao_w, ao_win;

    int n_cmp = 0;
    int n_bad = 0;
    int sd_cnt_m = 0;
    int sd_cnt_win = 0;

    instr_mix_profiler u_main (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_bank(rd_bank), .rd_sel(rd_sel),
        .rd_data(rd_m), .snap_done(sd_m), .any_ovf(ao_m));

    instr_mix_profiler #(.DEDUP(1'b0)) u_nodedup (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_bank(rd_bank), .rd_sel(rd_sel),
        .rd_data(rd_n), .snap_done(sd_n), .any_ovf(ao_n));

    instr_mix_profiler #(.CNT_W(13), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_bank(rd_bank), .rd_sel(rd_sel),
        .rd_data(rd_s), .snap_done(sd_s), .any_ovf(ao_s));

    instr_mix_profiler #(.CNT_W(13), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_bank(rd_bank), .rd_sel(rd_sel),
        .rd_data(rd_w), .snap_done(sd_w), .any_ovf(ao_w));

    instr_mix_profiler #(.WINDOW_LEN(64'd4)) u_win (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .instr(instr),
        .instr_valid(instr_valid), .snap_req(snap_req), .rd_bank(rd_bank), .rd_sel(rd_sel),
        .rd_data(rd_win), .snap_done(sd_win), .any_ovf(ao_win));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of snap_done for the instances that take snapshots.
    always @(negedge clk) begin
        if (sd_m)   sd_cnt_m++;
        if (sd_win) sd_cnt_win++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        enable      = 1'b1;
        clear       = 1'b0;
        instr       = 32'h0;
        instr_valid = 1'b0;
        snap_req    = 1'b0;
        rd_bank     = 1'b0;
        rd_sel      = 4'd0;
        rst_n       = 1'b0;
        #2;
        rst_n       = 1'b1;
    endtask

    task automatic issue(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    // Read one register of one instance: d 0=main 1=nodedup 2=sat 3=wrap 4=win.
    task automatic rd_chk(input int d, input logic bank, input logic [3:0] sel,
                          input logic [63:0] exp, input string nm);
        logic [63:0] act;
        instr_valid = 1'b0;
        snap_req    = 1'b0;
        clear       = 1'b0;
        rd_bank     = bank;
        rd_sel      = sel;
        tick();
        case (d)
            0:       act = 64'(rd_m);
            1:       act = 64'(rd_n);
            2:       act = 64'(rd_s);
            3:       act = 64'(rd_w);
            default: act = 64'(rd_win);
        endcase
        chk(nm, act, exp);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  cls;
    } vec_t;

    vec_t tbl[23];
    int   sd_base;

    initial begin
        tbl[0]  = '{32'h0000A103, 4'd0};   // LW
        tbl[1]  = '{32'h0020A023, 4'd1};   // SW
        tbl[2]  = '{32'h002081B3, 4'd2};   // ADD
        tbl[3]  = '{32'h00100093, 4'd2};   // ADDI
        tbl[4]  = '{32'h00000097, 4'd2};   // AUIPC
        tbl[5]  = '{32'h402081B3, 4'd3};   // SUB
        tbl[6]  = '{32'h0020C1B3, 4'd4};   // XOR
        tbl[7]  = '{32'h0010F093, 4'd4};   // ANDI
        tbl[8]  = '{32'h002091B3, 4'd5};   // SLL
        tbl[9]  = '{32'h4010D093, 4'd5};   // SRAI
        tbl[10] = '{32'h0020A1B3, 4'd6};   // SLT
        tbl[11] = '{32'h0010B093, 4'd6};   // SLTIU
        tbl[12] = '{32'h00208063, 4'd7};   // BEQ
        tbl[13] = '{32'h000000EF, 4'd8};   // JAL
        tbl[14] = '{32'h00008067, 4'd8};   // JALR
        tbl[15] = '{32'h00000073, 4'd9};   // ECALL
        tbl[16] = '{32'h0020A1AF, 4'd10};  // AMOADD.W
        tbl[17] = '{32'h000010B7, 4'd11};  // LUI
        tbl[18] = '{32'h0000000F, 4'd11};  // FENCE
        tbl[19] = '{32'h022081B3, 4'd11};  // MUL
        tbl[20] = '{32'h042081B3, 4'd11};  // OP f3=000 odd funct7
        tbl[21] = '{32'h022091B3, 4'd11};  // MULH (M-ext, not shift)
        tbl[22] = '{32'h0220C1B3, 4'd11};  // DIV (M-ext, not logic)

        // Reset state
        do_reset();
        tick();
        chk("rst_rd_data", 64'(rd_m), 64'h0);
        chk("rst_flags", 64'({ao_m, ao_n, ao_s, ao_w, ao_win, sd_m, sd_n, sd_s, sd_w, sd_win}), 64'h0);
        rd_chk(0, 1'b0, 4'd12, 64'd0, "rst_live_total");
        rd_chk(0, 1'b1, 4'd12, 64'd0, "rst_shadow_total");

        // Classification table: one word per reset, its class and total must read 1
        for (int i = 0; i < 23; i++) begin
            do_reset();
            issue(tbl[i].ins);
            rd_chk(0, 1'b0, tbl[i].cls, 64'd1, $sformatf("class_vec%0d", i));
            rd_chk(0, 1'b0, 4'd12, 64'd1, $sformatf("total_vec%0d", i));
        end

        // Four mixed words back to back
        do_reset();
        issue(32'h00100093);
        issue(32'h402081B3);
        issue(32'h0000A103);
        issue(32'h022081B3);
        rd_chk(0, 1'b0, 4'd2,  64'd1, "mix_add");
        rd_chk(0, 1'b0, 4'd3,  64'd1, "mix_sub");
        rd_chk(0, 1'b0, 4'd0,  64'd1, "mix_load");
        rd_chk(0, 1'b0, 4'd11, 64'd1, "mix_other");
        rd_chk(0, 1'b0, 4'd12, 64'd4, "mix_total");
        rd_chk(0, 1'b0, 4'd14, 64'd0, "mix_sel14");

        // Duplicate suppression
        do_reset();
        issue(32'h00100093);
        issue(32'h00100093);
        issue(32'h00100093);
        rd_chk(0, 1'b0, 4'd2, 64'd1, "dedup_add");
        rd_chk(1, 1'b0, 4'd2, 64'd3, "nodedup_add");

        // A first word of zero is counted
        do_reset();
        issue(32'h00000000);
        rd_chk(0, 1'b0, 4'd11, 64'd1, "zero_first_other");

        // 13-bit overflow: 8200 distinct branches
        do_reset();
        for (int k = 0; k < 8200; k++) begin
            issue({k[19:0], 5'd0, 7'b1100011});
        end
        rd_chk(2, 1'b0, 4'd7,  64'd8191,  "sat_branch");
        rd_chk(2, 1'b0, 4'd13, 64'h1080,  "sat_ovf_vec");
        chk("sat_any_ovf", 64'(ao_s), 64'd1);
        rd_chk(3, 1'b0, 4'd7,  64'd8,     "wrap_branch");
        rd_chk(3, 1'b0, 4'd13, 64'h1080,  "wrap_ovf_vec");
        rd_chk(0, 1'b0, 4'd7,  64'd8200,  "wide_branch");

        // Manual snapshot with a same-cycle store
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue(32'h00100093 + (32'(k) << 20));
        end
        sd_base     = sd_cnt_m;
        snap_req    = 1'b1;
        issue(32'h0020A023);
        snap_req    = 1'b0;
        rd_chk(0, 1'b1, 4'd2,  64'd5, "snap_sh_add");
        rd_chk(0, 1'b1, 4'd1,  64'd0, "snap_sh_store");
        rd_chk(0, 1'b1, 4'd12, 64'd5, "snap_sh_total");
        rd_chk(0, 1'b0, 4'd1,  64'd1, "snap_live_store");
        rd_chk(0, 1'b0, 4'd12, 64'd6, "snap_live_total");
        chk("snap_done_count", 64'(sd_cnt_m - sd_base), 64'd1);

        // Windowed capture every 4 counted instructions
        do_reset();
        sd_base = sd_cnt_win;
        for (int k = 0; k < 10; k++) begin
            issue(32'h000000EF | (32'(k) << 12));
        end
        rd_chk(4, 1'b1, 4'd8,  64'd4, "win_sh_jump");
        rd_chk(4, 1'b1, 4'd12, 64'd4, "win_sh_total");
        rd_chk(4, 1'b0, 4'd8,  64'd2, "win_live_jump");
        rd_chk(4, 1'b0, 4'd12, 64'd2, "win_live_total");
        chk("win_snap_count", 64'(sd_cnt_win - sd_base), 64'd2);

        // Pause, then clear (with a snapshot) while a load is valid
        do_reset();
        enable = 1'b0;
        issue(32'h0000A103);
        issue(32'h0010A103);
        issue(32'h0020A103);
        enable = 1'b1;
        rd_chk(0, 1'b0, 4'd0,  64'd0, "pause_load");
        rd_chk(0, 1'b0, 4'd12, 64'd0, "pause_total");
        issue(32'h0000A103);
        rd_chk(0, 1'b0, 4'd0, 64'd1, "pre_clear_load");
        clear    = 1'b1;
        snap_req = 1'b1;
        issue(32'h0030A103);
        clear    = 1'b0;
        snap_req = 1'b0;
        rd_chk(0, 1'b0, 4'd0,  64'd0, "clear_live_load");
        rd_chk(0, 1'b0, 4'd12, 64'd0, "clear_live_total");
        rd_chk(0, 1'b1, 4'd0,  64'd1, "clear_sh_load");
        // Dedup history was cleared, so the pre-clear word counts again
        issue(32'h0000A103);
        rd_chk(0, 1'b0, 4'd0, 64'd1, "clear_hist_load");

        // Reset mid-stream after a snapshot
        issue(32'h00100093);
        snap_req = 1'b1;
        issue(32'h00200093);
        snap_req = 1'b0;
        instr       = 32'h00300093;
        instr_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        instr_valid = 1'b0;
        chk("midrst_rd_data", 64'(rd_m), 64'h0);
        rd_chk(0, 1'b0, 4'd12, 64'd0, "midrst_live_total");
        rd_chk(0, 1'b0, 4'd2,  64'd0, "midrst_live_add");
        rd_chk(0, 1'b1, 4'd12, 64'd0, "midrst_sh_total");
        rd_chk(0, 1'b0, 4'd13, 64'd0, "midrst_ovf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
